mux_rr_arbiter: RTL and testbench
=================================

# mux_rr_arbiter

- Round-robin arbiter sharing one 8-bit 4:1 mux datapath between four byte sources.
- Picks a requester and drives the mux select from its grant.
- Moves the selected byte into a registered valid/ready output stage.
- Rotates priority after each burst. It sits between the four source registers and a single downstream consumer.

## Interface
Parameters:
- BURST, 4: maximum consecutive beats accepted from one source before priority rotates; legal range ≥ 1.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  4  req[i] high = source i presents a valid byte.
- data_a  in  8  source 0 byte.
- data_b  in  8  source 1 byte.
- data_c  in  8  source 2 byte.
- data_d  in  8  source 3 byte.
- ack  out  4  one-hot, combinational; ack[i] high = source i's byte is loaded at this rising edge.
- out_valid  out  1  output register holds an unconsumed byte.
- out_ready  in  1  consumer accepts out_data this cycle when out_valid is high.
- out_data  out  8  registered byte.
- out_src  out  2  index of the source that produced out_data.

## Operation
- State: FSM {IDLE, GRANT}, plus:
  - ptr (2 b): priority start, i.e. the index after the last grant.
  - gnt (2 b): current grant.
  - cnt: beats in the current burst, $clog2(BURST+1) bits.
- Reset values: state=IDLE, ptr=0, gnt=0, cnt=0, out_valid=0, out_data=8'h00, out_src=0, ack=4'b0000.
- IDLE:
  - ack is all-zero.
  - Scan req from ptr upward, modulo 4; the first set bit is the winner.
  - If a winner exists: gnt←winner, cnt←0, state→GRANT.
  - If no winner: stay in IDLE.
- GRANT: define load = req[gnt] & (~out_valid | out_ready).
  - load=1:
    - ack[gnt]=1.
    - out_data←mux(gnt) (0→data_a, 1→data_b, 2→data_c, 3→data_d), out_src←gnt, out_valid←1, cnt←cnt+1.
    - If cnt+1==BURST: ptr←gnt+1 (wraps 3→0), state→IDLE.
  - req[gnt]=0: no ack, ptr←gnt+1, state→IDLE (early release).
  - req[gnt]=1, blocked by backpressure (out_valid & ~out_ready): hold state; gnt, cnt and the output register are unchanged.
- Output stage:
  - When out_valid & out_ready and no load in the same cycle: out_valid←0.
  - While out_valid & ~out_ready: out_data and out_src are held stable.
- Simultaneous consume and load: out_valid stays 1 and the register takes the new byte. This sustains one beat per cycle inside a burst.
- Sources must hold data stable while req is high until they see ack. A source may drop req at any time; an unacked byte is never transferred.

## Timing
- req seen in IDLE at cycle 0 → first ack in cycle 1 → out_valid high in cycle 2.
- Within a burst with out_ready held high: one ack per cycle, back-to-back.
- Each burst switch inserts exactly one IDLE cycle with no ack.
- rst asserted at any time clears all state and outputs immediately, without waiting for a clock edge. The first arbitration happens in the first IDLE cycle after rst deasserts.
- A byte pending in the output register during reset is discarded.
- BURST=1: every grant is a single beat; strict rotation across active sources.

## Structure
- Shared include file `mux_arb_defs`:
  - NUM_SRC=4, DATA_W=8, SRC_W=2.
  - State encodings ST_IDLE=1'b0, ST_GRANT=1'b1.
- Sub-module `mux_4to1_8bit`: purely combinational, inputs a/b/c/d [7:0] and sel [1:0], output f [7:0]. It is instantiated once and driven by gnt.
- The round-robin priority scan is a local function inside mux_rr_arbiter.

## Test plan
- **Round-robin order:** data_a=8'h00, data_b=8'hF0, data_c=8'hAA, data_d=8'h55; req=4'b1111 held; BURST=1; out_ready=1 → out_data sequence 00,F0,AA,55,00,…; out_src 0,1,2,3,0; one idle cycle between beats.
- **Burst limit:** BURST=4, req=4'b0010 held, out_ready=1 → ack[1] in 4 consecutive cycles, one IDLE cycle, then the next 4 acks; every out_data=8'hF0 with out_src=1.
- **Backpressure:** out_ready=0 for 3 cycles while out_valid=1 → out_data, out_src and cnt are frozen and ack=0. Raising out_ready → the held byte is consumed and the next load happens in the same cycle.
- **Early release:** req=4'b0101 and source 0 is granted; drop req[0] after 2 acks → arbiter enters IDLE, then grants source 2 (out_src=2, out_data=8'hAA); ptr ends at 3.
- **Reset mid-operation:** assert rst asynchronously between edges while in GRANT with out_valid=1 → out_valid, out_data, out_src and ack read 0 before the next edge. After release with req=4'b1000, the grant goes to source 3 (scan starts from ptr=0).

Source files
------------

// File: rtl/mux_rr_arbiter_pkg.sv
// Shared definitions for the round-robin mux arbiter.
// Holds the source count, byte width, source-index width and the two FSM
// state encodings used by mux_rr_arbiter.
package mux_rr_arbiter_pkg;

  localparam int NUM_SRC = 4;
  localparam int DATA_W  = 8;
  localparam int SRC_W   = 2;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

endpackage

// File: rtl/mux_4to1_8bit.sv
// Purely combinational 4:1 byte multiplexer.
// Ports:
//   a, b, c, d : candidate bytes (sel 0..3)
//   sel        : select index
//   f          : selected byte
module mux_4to1_8bit (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic [7:0] c,
  input  logic [7:0] d,
  input  logic [1:0] sel,
  output logic [7:0] f
);

  always_comb begin
    f = a;
    case (sel)
      2'd0: f = a;
      2'd1: f = b;
      2'd2: f = c;
      2'd3: f = d;
      default: f = a;
    endcase
  end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter sharing one 4:1 byte mux between four sources and
// feeding a registered valid/ready output stage. A granted source may move
// up to BURST consecutive beats before priority rotates past it.
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   req               : per-source request (byte valid)
//   data_a..data_d    : source bytes 0..3
//   ack               : one-hot, combinational; source byte loads this edge
//   out_valid         : output register holds an unconsumed byte
//   out_ready         : consumer accepts out_data when out_valid is high
//   out_data, out_src : registered byte and the index of its source
module mux_rr_arbiter
  import mux_rr_arbiter_pkg::*;
#(
  parameter int BURST = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        req,
  input  logic [7:0]        data_a,
  input  logic [7:0]        data_b,
  input  logic [7:0]        data_c,
  input  logic [7:0]        data_d,
  output logic [3:0]        ack,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_data,
  output logic [1:0]        out_src
);

  localparam int CNT_W = $clog2(BURST + 1);
  // cnt value at which the current load is the last beat of the burst
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BURST - 1);

  logic [0:0]        state;
  logic [SRC_W-1:0]  ptr;
  logic [SRC_W-1:0]  gnt;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] mux_f;
  logic [SRC_W:0]    pick;
  logic              load;

  // First set request at or after start, wrapping modulo NUM_SRC.
  // MSB flags that a winner exists. Scanning from the far end down lets the
  // nearest candidate overwrite the result last.
  function automatic logic [SRC_W:0] rr_pick(input logic [NUM_SRC-1:0] r,
                                             input logic [SRC_W-1:0]   start);
    logic [SRC_W-1:0] idx;
    rr_pick = '0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      idx = start + SRC_W'(k);
      if (r[idx]) rr_pick = {1'b1, idx};
    end
  endfunction

  assign pick = rr_pick(req, ptr);

  // A beat moves only while granted, still requested, and the output
  // register is empty or being drained this same cycle.
  assign load = (state == ST_GRANT) && req[gnt] && (!out_valid || out_ready);

  always_comb begin
    ack = '0;
    if (load) ack[gnt] = 1'b1;
  end

  mux_4to1_8bit u_mux (
    .a   (data_a),
    .b   (data_b),
    .c   (data_c),
    .d   (data_d),
    .sel (gnt),
    .f   (mux_f)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      ptr   <= '0;
      gnt   <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick[SRC_W]) begin
            gnt   <= pick[SRC_W-1:0];
            cnt   <= '0;
            state <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          if (!req[gnt]) begin
            // early release: rotate past the source that let go
            ptr   <= gnt + SRC_W'(1);
            state <= ST_IDLE;
          end else if (load) begin
            cnt <= cnt + CNT_W'(1);
            if (cnt == LAST) begin
              ptr   <= gnt + SRC_W'(1);
              state <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Output register: a load wins over a drain, so consume+load in one cycle
  // keeps out_valid high and sustains one beat per cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= mux_f;
      out_src   <= gnt;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Self-checking bench for mux_rr_arbiter. Two instances share all inputs:
// index 0 has BURST=1, index 1 has BURST=4.
module tb_mux_rr_arbiter;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [3:0]      req = '0;
  logic [7:0]      da = '0, db = '0, dc = '0, dd = '0;
  logic            ready = 1'b1;
  logic [1:0][3:0] ack;
  logic [1:0]      ov;
  logic [1:0][7:0] od;
  logic [1:0][1:0] os;

  int chk = 0;
  int pass = 0;

  always #5 clk = ~clk;

  mux_rr_arbiter #(.BURST(1)) u_b1 (
    .clk(clk), .rst(rst), .req(req),
    .data_a(da), .data_b(db), .data_c(dc), .data_d(dd),
    .ack(ack[0]), .out_valid(ov[0]), .out_ready(ready),
    .out_data(od[0]), .out_src(os[0])
  );

  mux_rr_arbiter #(.BURST(4)) u_b4 (
    .clk(clk), .rst(rst), .req(req),
    .data_a(da), .data_b(db), .data_c(dc), .data_d(dd),
    .ack(ack[1]), .out_valid(ov[1]), .out_ready(ready),
    .out_data(od[1]), .out_src(os[1])
  );

  // Reference model: who owns the mux, how many beats it has moved, where
  // the next search starts, and what the output register holds.
  int         m_busy [2];
  int         m_own  [2];
  int         m_beats[2];
  int         m_start[2];
  int         m_burst[2] = '{1, 4};
  logic       m_ov   [2];
  logic [7:0] m_od   [2];
  int         m_os   [2];

  function automatic logic [7:0] src_byte(int i);
    case (i)
      0: return da;
      1: return db;
      2: return dc;
      default: return dd;
    endcase
  endfunction

  function automatic bit m_fire(int k);
    return (m_busy[k] != 0) && req[m_own[k]] && (!m_ov[k] || ready);
  endfunction

  task automatic model_step(int k);
    bit fire, drain, found;
    fire  = m_fire(k);
    drain = m_ov[k] && ready && !fire;
    if (m_busy[k] == 0) begin
      found = 0;
      for (int j = 0; j < 4; j++) begin
        int s;
        s = (m_start[k] + j) % 4;
        if (!found && req[s]) begin
          found = 1; m_busy[k] = 1; m_own[k] = s; m_beats[k] = 0;
        end
      end
    end else if (!req[m_own[k]]) begin
      m_busy[k]  = 0;
      m_start[k] = (m_own[k] + 1) % 4;
    end else if (fire) begin
      m_od[k] = src_byte(m_own[k]);
      m_os[k] = m_own[k];
      m_ov[k] = 1'b1;
      m_beats[k]++;
      if (m_beats[k] == m_burst[k]) begin
        m_busy[k]  = 0;
        m_start[k] = (m_own[k] + 1) % 4;
      end
    end
    if (drain) m_ov[k] = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1; req = '0; ready = 1'b1;
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk); #1;
    for (int k = 0; k < 2; k++) begin
      chk++; if (ack[k] !== 4'b0000) $display("FAIL reset_ack[%0d] got %b exp 0000", k, ack[k]); else pass++;
      chk++; if (ov[k] !== 1'b0) $display("FAIL reset_valid[%0d] got %b exp 0", k, ov[k]); else pass++;
      chk++; if (od[k] !== 8'h00) $display("FAIL reset_data[%0d] got %h exp 00", k, od[k]); else pass++;
      chk++; if (os[k] !== 2'd0) $display("FAIL reset_src[%0d] got %0d exp 0", k, os[k]); else pass++;
    end
  endtask

  task automatic test_rr_order();
    logic [7:0] pat [4] = '{8'h00, 8'hF0, 8'hAA, 8'h55};
    logic [3:0] e;
    do_reset();
    da = 8'h00; db = 8'hF0; dc = 8'hAA; dd = 8'h55; req = 4'b1111; ready = 1'b1;
    #1;
    chk++; if (ack[0] !== 4'b0000) $display("FAIL rr_idle_ack got %b exp 0000", ack[0]); else pass++;
    for (int b = 0; b < 8; b++) begin
      e = 4'b0001 << (b % 4);
      @(negedge clk); #1;
      chk++; if (ack[0] !== e) $display("FAIL rr_ack beat%0d got %b exp %b", b, ack[0], e); else pass++;
      @(negedge clk); #1;
      chk++; if (ack[0] !== 4'b0000) $display("FAIL rr_gap beat%0d got %b exp 0000", b, ack[0]); else pass++;
      chk++; if (ov[0] !== 1'b1) $display("FAIL rr_valid beat%0d got %b exp 1", b, ov[0]); else pass++;
      chk++; if (od[0] !== pat[b % 4]) $display("FAIL rr_data beat%0d got %h exp %h", b, od[0], pat[b % 4]); else pass++;
      chk++; if (os[0] !== 2'(b % 4)) $display("FAIL rr_src beat%0d got %0d exp %0d", b, os[0], b % 4); else pass++;
    end
  endtask

  task automatic test_burst();
    logic [3:0] ea;
    logic       ev;
    do_reset();
    db = 8'hF0; req = 4'b0010; ready = 1'b1;
    for (int c = 0; c <= 10; c++) begin
      if (c != 0) @(negedge clk);
      #1;
      ea = ((c >= 1 && c <= 4) || (c >= 6 && c <= 9)) ? 4'b0010 : 4'b0000;
      ev = (c >= 2 && c <= 5) || (c >= 7 && c <= 10);
      chk++; if (ack[1] !== ea) $display("FAIL burst_ack cyc%0d got %b exp %b", c, ack[1], ea); else pass++;
      chk++; if (ov[1] !== ev) $display("FAIL burst_valid cyc%0d got %b exp %b", c, ov[1], ev); else pass++;
      if (ev) begin
        chk++; if (od[1] !== 8'hF0 || os[1] !== 2'd1)
          $display("FAIL burst_out cyc%0d got %h/%0d exp f0/1", c, od[1], os[1]); else pass++;
      end
    end
  endtask

  task automatic test_backpressure();
    logic [3:0] ea [9] = '{4'h0, 4'h2, 4'h0, 4'h0, 4'h0, 4'h2, 4'h2, 4'h2, 4'h0};
    logic [7:0] ed;
    do_reset();
    db = 8'hF0; req = 4'b0010; ready = 1'b1;
    for (int c = 0; c <= 8; c++) begin
      if (c != 0) @(negedge clk);
      if (c == 2) begin ready = 1'b0; db = 8'h11; end
      if (c == 5) ready = 1'b1;
      #1;
      chk++; if (ack[1] !== ea[c]) $display("FAIL bp_ack cyc%0d got %b exp %b", c, ack[1], ea[c]); else pass++;
      if (c >= 2) begin
        ed = (c <= 5) ? 8'hF0 : 8'h11;
        chk++; if (ov[1] !== 1'b1) $display("FAIL bp_valid cyc%0d got %b exp 1", c, ov[1]); else pass++;
        chk++; if (od[1] !== ed || os[1] !== 2'd1)
          $display("FAIL bp_out cyc%0d got %h/%0d exp %h/1", c, od[1], os[1], ed); else pass++;
      end
    end
  endtask

  task automatic test_early_release();
    logic [3:0] ea [9] = '{4'h0, 4'h1, 4'h1, 4'h0, 4'h0, 4'h4, 4'h0, 4'h0, 4'h8};
    do_reset();
    da = 8'h00; dc = 8'hAA; dd = 8'h55; req = 4'b0101; ready = 1'b1;
    for (int c = 0; c <= 8; c++) begin
      if (c != 0) @(negedge clk);
      if (c == 3) req = 4'b0100;
      if (c == 6) req = 4'b0000;
      if (c == 7) req = 4'b1101;
      #1;
      chk++; if (ack[1] !== ea[c]) $display("FAIL er_ack cyc%0d got %b exp %b", c, ack[1], ea[c]); else pass++;
      if (c == 6) begin
        chk++; if (ov[1] !== 1'b1 || od[1] !== 8'hAA || os[1] !== 2'd2)
          $display("FAIL er_out got %b/%h/%0d exp 1/aa/2", ov[1], od[1], os[1]); else pass++;
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    db = 8'hF0; dd = 8'h55; req = 4'b0010; ready = 1'b1;
    @(negedge clk);
    @(negedge clk); #1;
    chk++; if (ov[1] !== 1'b1) $display("FAIL rm_pre_valid got %b exp 1", ov[1]); else pass++;
    #2 rst = 1'b1;
    #1;
    chk++; if (ov[1] !== 1'b0) $display("FAIL rm_valid got %b exp 0", ov[1]); else pass++;
    chk++; if (od[1] !== 8'h00) $display("FAIL rm_data got %h exp 00", od[1]); else pass++;
    chk++; if (os[1] !== 2'd0) $display("FAIL rm_src got %0d exp 0", os[1]); else pass++;
    chk++; if (ack[1] !== 4'b0000) $display("FAIL rm_ack got %b exp 0000", ack[1]); else pass++;
    @(negedge clk); rst = 1'b0; req = 4'b1000; #1;
    chk++; if (ack[1] !== 4'b0000) $display("FAIL rm_idle_ack got %b exp 0000", ack[1]); else pass++;
    @(negedge clk); #1;
    chk++; if (ack[1] !== 4'b1000) $display("FAIL rm_grant_ack got %b exp 1000", ack[1]); else pass++;
    @(negedge clk); #1;
    chk++; if (ov[1] !== 1'b1 || od[1] !== 8'h55 || os[1] !== 2'd3)
      $display("FAIL rm_out got %b/%h/%0d exp 1/55/3", ov[1], od[1], os[1]); else pass++;
  endtask

  task automatic test_random();
    logic [3:0] ea;
    do_reset();
    for (int k = 0; k < 2; k++) begin
      m_busy[k] = 0; m_own[k] = 0; m_beats[k] = 0; m_start[k] = 0;
      m_ov[k] = 1'b0; m_od[k] = 8'h00; m_os[k] = 0;
    end
    for (int n = 0; n < 800; n++) begin
      if (n != 0) @(negedge clk);
      for (int i = 0; i < 4; i++)
        if ($urandom_range(3) == 0) req[i] = ~req[i];
      da = 8'($urandom); db = 8'($urandom); dc = 8'($urandom); dd = 8'($urandom);
      ready = ($urandom_range(3) != 0);
      #1;
      for (int k = 0; k < 2; k++) begin
        ea = m_fire(k) ? (4'b0001 << m_own[k]) : 4'b0000;
        chk++; if (ack[k] !== ea) $display("FAIL rnd_ack[%0d] n%0d got %b exp %b", k, n, ack[k], ea); else pass++;
        chk++; if (ov[k] !== m_ov[k] || od[k] !== m_od[k] || os[k] !== 2'(m_os[k]))
          $display("FAIL rnd_out[%0d] n%0d got %b/%h/%0d exp %b/%h/%0d", k, n,
                   ov[k], od[k], os[k], m_ov[k], m_od[k], m_os[k]); else pass++;
        model_step(k);
      end
    end
  endtask

  initial begin
    test_reset();
    test_rr_order();
    test_burst();
    test_backpressure();
    test_early_release();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", pass, chk);
    $finish;
  end

endmodule
